// File: rtl/imem_loader_pkg.sv
`default_nettype none
// =============================================================================
// Module : imem_loader_pkg
// Brief  : Shared widths, FSM state encoding and helpers for imem_loader.
// Rev    : 1.0  initial release
// =============================================================================
package imem_loader_pkg;

  // Widths shared with the instruction_memory and mips_lite instances.
  localparam int DEFAULT_ADDR_W = 9;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// =============================================================================
// Module : imem_loader_if
// Brief  : Valid/ready program-word stream feeding the instruction memory loader.
// Rev    : 1.0  initial release
// =============================================================================
interface imem_loader_if #(
  parameter int DATA_W = imem_loader_pkg::DEFAULT_DATA_W
) ();
  import imem_loader_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);

endinterface
`default_nettype wire

// File: rtl/imem_loader_run_watchdog.sv
`default_nettype none
// =============================================================================
// Module : imem_loader_run_watchdog
// Brief  : Loadable down-counter; expired is high while the count sits at zero.
// Rev    : 1.0  initial release
// =============================================================================
module imem_loader_run_watchdog
  import imem_loader_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  wire             clk,
  input  wire             rst,
  input  wire             load,
  input  wire [CNT_W-1:0] load_val,
  output logic            expired
);

  logic [CNT_W-1:0] r_count;

  // Loading N gives N+1 cycles until expiry is acted on, counting the load cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// =============================================================================
// Module : imem_loader
// Brief  : Boot sequencer: clears instruction memory, streams a program in,
//          runs the core and flags done on fetch-past-end or budget expiry.
//          Define LOADER_CHECKSUM_EN to add a running checksum output.
// Rev    : 1.0  initial release
// =============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int CLR_CYCLES = 4,
  parameter int RUN_BUDGET = 4096
) (
  input  wire               clk,
  input  wire               rst,
  input  wire               start,
  imem_loader_if.slave      s,
  output logic              inst_mem_rstn,
  output logic              inst_mem_wr_en,
  output logic [ADDR_W-1:0] inst_mem_wr_addr,
  output logic [DATA_W-1:0] inst_mem_wr_data,
  input  wire               inst_mem_rd_en,
  input  wire [ADDR_W-1:0]  inst_mem_addr,
  output logic              cpu_rstn,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic              timeout,
  output logic              done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int CNT_W = $clog2(max_int(CLR_CYCLES, RUN_BUDGET)) + 1;
  localparam logic [CNT_W-1:0] c_clr_load = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_run_load = CNT_W'(RUN_BUDGET - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_last_seen;
  logic             w_wd_load;
  logic [CNT_W-1:0] w_wd_val;
  logic             w_expired;
  logic             w_ready;
  logic             w_hs;
  logic             w_wr;
  logic             w_start_ok;
  logic             w_fetch_end;

  imem_loader_run_watchdog #(.CNT_W(CNT_W)) run_watchdog (
    .clk      (clk),
    .rst      (rst),
    .load     (w_wd_load),
    .load_val (w_wd_val),
    .expired  (w_expired)
  );

  assign w_ready     = (r_state == ST_LOAD) && !r_last_seen;
  assign s.s_ready   = w_ready;
  assign w_hs        = s.s_valid && w_ready;
  // A full word_count (top bit set) means the address space is exhausted.
  assign w_wr        = w_hs && !word_count[ADDR_W];
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_fetch_end = inst_mem_rd_en && ({1'b0, inst_mem_addr} >= word_count);
  assign cpu_rstn    = (r_state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_wd_load  = 1'b0;
    w_wd_val   = c_clr_load;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nx = ST_CLEAR;
          w_wd_load  = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (w_expired) w_state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        // The cycle after the last handshake carries its write (or drop).
        if (r_last_seen) begin
          w_state_nx = ST_RUN;
          w_wd_load  = 1'b1;
          w_wd_val   = c_run_load;
        end
      end
      ST_RUN: begin
        if (w_fetch_end || w_expired) w_state_nx = ST_DONE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_mem_rstn    <= 1'b0;
      inst_mem_wr_en   <= 1'b0;
      inst_mem_wr_addr <= '0;
      inst_mem_wr_data <= '0;
      word_count       <= '0;
      overflow         <= 1'b0;
      timeout          <= 1'b0;
      done             <= 1'b0;
      r_last_seen      <= 1'b0;
    end else begin
      inst_mem_rstn  <= (w_state_nx != ST_CLEAR);
      inst_mem_wr_en <= w_wr;
      if (w_wr) begin
        inst_mem_wr_addr <= word_count[ADDR_W-1:0];
        inst_mem_wr_data <= s.s_data;
        word_count       <= word_count + (ADDR_W+1)'(1);
      end
      if (w_hs && word_count[ADDR_W]) overflow <= 1'b1;
      if (w_hs && s.s_last) r_last_seen <= 1'b1;
      if (w_start_ok) begin
        done        <= 1'b0;
        overflow    <= 1'b0;
        timeout     <= 1'b0;
        word_count  <= '0;
        r_last_seen <= 1'b0;
      end
      if ((r_state == ST_RUN) && (w_state_nx == ST_DONE)) begin
        done    <= 1'b1;
        timeout <= w_expired;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      checksum <= '0;
    end else if (w_wr) begin
      checksum <= checksum + s.s_data;
    end
  end
`endif

endmodule
`default_nettype wire
